// File: rtl/vend_pkg.sv
// Shared types and constants for the vending controller: state encoding, coin values, price table.
// Build with CHANGE_RETURN_EN defined to include the CHANGE state.
package vend_pkg;

  localparam int COIN_5  = 5;
  localparam int COIN_10 = 10;

  localparam logic [7:0] PRICE [0:3] = '{8'd15, 8'd20, 8'd25, 8'd40};

`ifdef CHANGE_RETURN_EN
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    CHANGE   = 2'd2,
    DONE     = 2'd3
  } state_t;
`else
  // CHANGE encoding left unused so DONE keeps the same code in both builds
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DISPENSE = 2'd1,
    DONE     = 2'd3
  } state_t;
`endif

  function automatic logic [7:0] item_price(input logic [1:0] item);
    return PRICE[item];
  endfunction

endpackage

// File: rtl/vend_controller_if.sv
// Bundles the coin-counter/keypad side and the actuator side of the vending controller.
// master drives requests and observes pulses; slave is the controller's view.
interface vend_controller_if #(
  parameter int BAL_W = 8
);
  logic [BAL_W-1:0] balance;
  logic             select;
  logic [1:0]       item_sel;
  logic             cancel;
  logic             dispense;
  logic             change_10;
  logic             change_5;
  logic             clear_balance;
  logic             insufficient;
  logic             busy;

  modport master (
    output balance, select, item_sel, cancel,
    input  dispense, change_10, change_5, clear_balance, insufficient, busy
  );

  modport slave (
    input  balance, select, item_sel, cancel,
    output dispense, change_10, change_5, clear_balance, insufficient, busy
  );
endinterface

// File: rtl/vend_controller.sv
// Vending FSM: dispense on a funded select, return change in 10/5 coins, then clear the counter.
// Change return exists only with CHANGE_RETURN_EN defined; otherwise any excess is forfeited.
module vend_controller
  import vend_pkg::*;
#(
  parameter int BAL_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [BAL_W-1:0] balance,
  input  logic             select,
  input  logic [1:0]       item_sel,
  input  logic             cancel,
  output logic             dispense,
  output logic             change_10,
  output logic             change_5,
  output logic             clear_balance,
  output logic             insufficient,
  output logic             busy
);

  state_t           state;
  logic [BAL_W-1:0] price_w;
  logic             go_pay;

  assign price_w = BAL_W'(item_price(item_sel));

  // Cancel outranks select in IDLE; both are ignored once the FSM has left IDLE.
  assign go_pay = ((state == IDLE) && cancel) || (state == DISPENSE)
`ifdef CHANGE_RETURN_EN
                  || (state == CHANGE)
`endif
                  ;

`ifdef CHANGE_RETURN_EN
  localparam logic [BAL_W-1:0] FIVE = BAL_W'(COIN_5);
  localparam logic [BAL_W-1:0] TEN  = BAL_W'(COIN_10);

  logic [BAL_W-1:0] remaining;
  logic [BAL_W-1:0] pay_src;
  logic             pay_more;
  logic             pay_ten;

  // Each coin is subtracted on entry to its CHANGE cycle, so remaining holds what is still owed.
  assign pay_src  = (state == IDLE) ? balance : remaining;
  assign pay_more = (pay_src >= FIVE);
  assign pay_ten  = (pay_src >= TEN);
`else
  assign change_10 = 1'b0;
  assign change_5  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      dispense      <= 1'b0;
      clear_balance <= 1'b0;
      insufficient  <= 1'b0;
      busy          <= 1'b0;
`ifdef CHANGE_RETURN_EN
      change_10     <= 1'b0;
      change_5      <= 1'b0;
      remaining     <= '0;
`endif
    end else begin
      dispense      <= 1'b0;
      clear_balance <= 1'b0;
      insufficient  <= 1'b0;
      busy          <= 1'b0;
`ifdef CHANGE_RETURN_EN
      change_10     <= 1'b0;
      change_5      <= 1'b0;
`endif
      if (go_pay) begin
`ifdef CHANGE_RETURN_EN
        if (pay_more) begin
          state     <= CHANGE;
          busy      <= 1'b1;
          change_10 <= pay_ten;
          change_5  <= !pay_ten;
          remaining <= pay_src - (pay_ten ? TEN : FIVE);
        end else begin
          // Sub-5 remainder is forfeited silently.
          state         <= DONE;
          busy          <= 1'b1;
          clear_balance <= 1'b1;
          remaining     <= '0;
        end
`else
        state         <= DONE;
        busy          <= 1'b1;
        clear_balance <= 1'b1;
`endif
      end else if ((state == IDLE) && select) begin
        if (balance >= price_w) begin
          state    <= DISPENSE;
          busy     <= 1'b1;
          dispense <= 1'b1;
`ifdef CHANGE_RETURN_EN
          remaining <= balance - price_w;
`endif
        end else begin
          insufficient <= 1'b1;
        end
      end else if (state != IDLE) begin
        state <= IDLE;
      end
    end
  end

endmodule

// File: doc/vend_controller.md
VEND_CONTROLLER -- requirements
Module: vend_controller

Interface
REQ-001 SHALL have parameter: BAL_W, 8, width of balance and internal remaining register.
REQ-002 SHALL have port: clk  input  1  single system clock; all logic on rising edge.
REQ-003 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port: balance  input  BAL_W  current credit in rupees from the coin counter.
REQ-005 SHALL have port: select  input  1  one-cycle purchase request.
REQ-006 SHALL have port: item_sel  input  2  item index, sampled with select.
REQ-007 SHALL have port: cancel  input  1  one-cycle refund request.
REQ-008 SHALL have port: dispense  output  1  one-cycle item release pulse.
REQ-009 SHALL have port: change_10  output  1  one-cycle pulse per ₹10 coin returned.
REQ-010 SHALL have port: change_5  output  1  one-cycle pulse per ₹5 coin returned.
REQ-011 SHALL have port: clear_balance  output  1  one-cycle pulse that zeroes the coin counter.
REQ-012 SHALL have port: insufficient  output  1  one-cycle pulse when a select is refused.
REQ-013 SHALL have port: busy  output  1  high whenever state != IDLE; upstream gates coin acceptance with it.

Function
REQ-014 SHALL implement states IDLE, DISPENSE, CHANGE, DONE; all outputs SHALL be registered, Moore-decoded.
REQ-015 In IDLE, cancel SHALL take priority over a simultaneous select.
REQ-016 IDLE + select, balance >= PRICE[item_sel]: SHALL load remaining = balance - price and go to DISPENSE.
REQ-017 IDLE + select, balance < price: SHALL pulse insufficient for one cycle at the next edge, stay IDLE, and leave balance untouched.
REQ-018 IDLE + cancel: SHALL load remaining = balance; go to CHANGE if remaining >= 5, else go to DONE.
REQ-019 DISPENSE SHALL last one cycle with dispense=1, then go to CHANGE if remaining >= 5, else go to DONE.
REQ-020 Each CHANGE cycle SHALL emit exactly one coin and subtract its value from remaining:
- remaining >= 10: change_10, subtract 10.
- otherwise: change_5, subtract 5.
REQ-021 CHANGE SHALL go to DONE once post-subtraction remaining < 5.
REQ-022 DONE SHALL last one cycle with clear_balance=1, then return to IDLE.
REQ-023 A remainder of 1..4 SHALL be forfeited, with no pulse.
REQ-024 Latency: select sampled at edge k -> dispense high in cycle k+1; first change pulse in k+2.
REQ-025 select and cancel SHALL be ignored while busy.
REQ-026 remaining SHALL never underflow; all arithmetic is unsigned BAL_W-bit.
REQ-027 At most one of dispense/change_10/change_5/clear_balance/insufficient SHALL be high in any cycle.

Reset
REQ-028 reset SHALL force IDLE, remaining=0, and every output 0 at the next edge.
REQ-029 reset mid-vend SHALL abort the vend without emitting clear_balance; the shared reset clears the coin counter.

Configuration
REQ-030 With CHANGE_RETURN_EN defined, the block SHALL behave as REQ-018..REQ-023.
REQ-031 Without CHANGE_RETURN_EN:
- CHANGE state and the remaining register SHALL be omitted.
- change_10 and change_5 SHALL be tied 0.
- DISPENSE and IDLE+cancel SHALL go directly to DONE, forfeiting any excess.

Structure
REQ-032 Package vend_pkg SHALL hold the state enum, coin constants (5, 10), and the PRICE table {15, 20, 25, 40} indexed by item_sel.
REQ-033 The block SHALL be a single module with no sub-module; price lookup SHALL be a package function.

Verification
REQ-034 balance=40, select item_sel=0 at edge k -> outputs SHALL be:
- dispense k+1;
- change_10 k+2 and k+3;
- change_5 k+4;
- clear_balance k+5;
- busy low at k+6.
REQ-035 balance=10, select item_sel=1 -> insufficient one cycle; no other pulses; busy stays 0.
REQ-036 balance=25, cancel and select in the same cycle -> change_10, change_10, change_5, clear_balance; no dispense.
REQ-037 balance=23, select item_sel=0 -> dispense, change_5, clear_balance; ₹3 forfeited.
REQ-038 reset asserted in the cycle of the first change_10 (balance=40, item 0) -> all outputs 0 next cycle, IDLE, no clear_balance.
REQ-039 CHANGE_RETURN_EN undefined, balance=40, item 0 -> dispense k+1, clear_balance k+2, change outputs never high.
